// File: rtl/cmd_sequencer.sv
// Command front-end for the breadboard datapath: buffers commands in a small FIFO,
// issues one per cycle, polls ATLOC after GOTO, halts on SHUTDOWN, flushes on RESET.
module cmd_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned AW      = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_opcode,
   input  logic [7:0]    cmd_data,
   input  logic [15:0]   cmd_loc,
   input  logic [7:0]    alb,
   output logic [3:0]    opcode,
   output logic [7:0]    DataIn,
   output logic [15:0]   LocIn,
   output logic          busy,
   output logic [AW:0]   count,
   output logic          timeout_err
);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 16;
   localparam int unsigned EW = 28;

   localparam logic [3:0] OP_NOOP     = 4'b0000;
   localparam logic [3:0] OP_GOTO     = 4'b0110;
   localparam logic [3:0] OP_ATLOC    = 4'b1010;
   localparam logic [3:0] OP_RESET    = 4'b1100;
   localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

   typedef enum logic [1:0] {IDLE, WAIT_LOC, HALT} state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [TW-1:0]   timer, timer_nxt;
   logic [15:0]     target, target_nxt;
   logic [CW-1:0]   count_nxt;
   logic [3:0]      op_nxt;
   logic [7:0]      data_nxt;
   logic [15:0]     loc_nxt;
   logic            err_nxt;
   logic            accept, is_reset_cmd, queueable, push, pop, flush;
   logic [EW-1:0]   head;

   // Opcodes that occupy a FIFO slot; NOOP, RESET and undefined codes never do.
   always_comb begin
      queueable = 1'b0;
      case (cmd_opcode)
         4'b0100, 4'b0101, 4'b0110, 4'b0111,
         4'b1000, 4'b1001, 4'b1010, 4'b1101: queueable = 1'b1;
         default:                            queueable = 1'b0;
      endcase
   end

   assign is_reset_cmd = (cmd_opcode == OP_RESET);
   assign cmd_ready    = (count != CW'(DEPTH)) || is_reset_cmd;
   assign accept       = cmd_valid && cmd_ready;
   assign push         = accept && queueable;
   assign head         = mem[rd_ptr];

   // Next-state and next-output decode; a RESET command overrides everything else.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      target_nxt = target;
      err_nxt    = timeout_err;
      op_nxt     = OP_NOOP;
      data_nxt   = 8'd0;
      loc_nxt    = 16'd0;
      pop        = 1'b0;
      flush      = 1'b0;
      if (accept && is_reset_cmd) begin
         flush     = 1'b1;
         state_nxt = IDLE;
         timer_nxt = TW'(0);
         err_nxt   = 1'b0;
         op_nxt    = OP_RESET;
      end else begin
         case (state)
            IDLE: begin
               if (count != CW'(0)) begin
                  pop      = 1'b1;
                  op_nxt   = head[27:24];
                  data_nxt = head[23:16];
                  loc_nxt  = head[15:0];
                  if (head[27:24] == OP_GOTO) begin
                     state_nxt  = WAIT_LOC;
                     target_nxt = head[15:0];
                     timer_nxt  = TW'(0);
                  end else if (head[27:24] == OP_SHUTDOWN) begin
                     state_nxt = HALT;
                  end
               end
            end
            WAIT_LOC: begin
               if (alb != 8'd0) begin
                  state_nxt = IDLE;
               end else if (timer == TW'(TIMEOUT)) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  op_nxt    = OP_ATLOC;
                  loc_nxt   = target;
                  timer_nxt = timer + TW'(1);
               end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
         endcase
      end

      if (flush)
         count_nxt = CW'(0);
      else
         count_nxt = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rd_ptr      <= AW'(0);
         wr_ptr      <= AW'(0);
         count       <= CW'(0);
         timer       <= TW'(0);
         target      <= 16'd0;
         timeout_err <= 1'b0;
         opcode      <= OP_NOOP;
         DataIn      <= 8'd0;
         LocIn       <= 16'd0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         timer       <= timer_nxt;
         target      <= target_nxt;
         timeout_err <= err_nxt;
         opcode      <= op_nxt;
         DataIn      <= data_nxt;
         LocIn       <= loc_nxt;
         busy        <= (state_nxt != IDLE) || (count_nxt != CW'(0));
         if (flush) begin
            rd_ptr <= AW'(0);
            wr_ptr <= AW'(0);
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Storage array carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= {cmd_opcode, cmd_data, cmd_loc};
   end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized + directed bench for cmd_sequencer: a queue-based reference model
// predicts issued commands into a scoreboard that a separate monitor drains.
module tb_cmd_sequencer;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned TO    = 8;

   logic        clk = 1'b0;
   logic        reset, cmd_valid, cmd_ready;
   logic [3:0]  cmd_opcode, opcode;
   logic [7:0]  cmd_data, alb, DataIn;
   logic [15:0] cmd_loc, LocIn;
   logic        busy, timeout_err;
   logic [AW:0] count;

   cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cmd_loc(cmd_loc), .alb(alb),
      .opcode(opcode), .DataIn(DataIn), .LocIn(LocIn), .busy(busy),
      .count(count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] op; logic [7:0] d; logic [15:0] l; } ent_t;
   typedef struct { int cyc; ent_t e; } exp_t;
   typedef enum { M_IDLE, M_WAIT, M_HALT } mode_t;

   ent_t   mq[$];
   exp_t   sb[$];
   mode_t  m_mode = M_IDLE;
   int     m_timer = 0;
   logic [15:0] m_tgt = 16'd0;
   logic   m_err = 1'b0;
   int     cyc = 0;
   int     tests = 0;
   int     fails = 0;

   function automatic bit is_queued_op(logic [3:0] op);
      return op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
   endfunction

   function automatic void expect_out(logic [3:0] op, logic [7:0] d, logic [15:0] l);
      exp_t x;
      x.cyc = cyc; x.e.op = op; x.e.d = d; x.e.l = l;
      sb.push_back(x);
   endfunction

   // Reference model: applies the command rules once per clock edge.
   always @(posedge clk) begin
      ent_t e;
      bit   rdy;
      cyc++;
      if (reset) begin
         mq.delete(); m_mode = M_IDLE; m_timer = 0; m_err = 1'b0;
      end else begin
         rdy = (mq.size() != DEPTH) || (cmd_opcode == 4'hC);
         if (cmd_valid && rdy && cmd_opcode == 4'hC) begin
            mq.delete(); m_mode = M_IDLE; m_timer = 0; m_err = 1'b0;
            expect_out(4'hC, 8'd0, 16'd0);
         end else begin
            if (m_mode == M_IDLE && mq.size() > 0) begin
               e = mq.pop_front();
               expect_out(e.op, e.d, e.l);
               if (e.op == 4'h6) begin m_mode = M_WAIT; m_tgt = e.l; m_timer = 0; end
               else if (e.op == 4'hD) m_mode = M_HALT;
            end else if (m_mode == M_WAIT) begin
               if (alb != 0) m_mode = M_IDLE;
               else if (m_timer == TO) begin m_err = 1'b1; m_mode = M_IDLE; end
               else begin expect_out(4'hA, 8'd0, m_tgt); m_timer++; end
            end
            if (cmd_valid && rdy && is_queued_op(cmd_opcode)) begin
               e.op = cmd_opcode; e.d = cmd_data; e.l = cmd_loc;
               mq.push_back(e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Monitor: drains the scoreboard whenever the DUT drives a command.
   always @(negedge clk) begin
      exp_t x;
      if (cyc >= 1) begin
         if (opcode != 4'h0 || DataIn != 8'h0 || LocIn != 16'h0) begin
            if (sb.size() == 0) begin
               chk("unexpected_issue", {16'h0, 4'h0, opcode, DataIn}, 32'h0);
            end else begin
               x = sb.pop_front();
               chk("issue_cycle", 32'(cyc), 32'(x.cyc));
               chk("issue_opcode", 32'(opcode), 32'(x.e.op));
               chk("issue_data", 32'(DataIn), 32'(x.e.d));
               chk("issue_loc", 32'(LocIn), 32'(x.e.l));
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            chk("missed_issue", 32'(opcode), 32'(x.e.op));
         end
         chk("count", 32'(count), 32'(mq.size()));
         chk("timeout_err", 32'(timeout_err), 32'(m_err));
         chk("busy", 32'(busy), 32'((m_mode != M_IDLE) || (mq.size() != 0)));
         chk("cmd_ready", 32'(cmd_ready), 32'((mq.size() != DEPTH) || (cmd_opcode == 4'hC)));
      end
   end

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] d,
                        input logic [15:0] l, input logic [7:0] a);
      cmd_valid = v; cmd_opcode = op; cmd_data = d; cmd_loc = l; alb = a;
      @(posedge clk); #2;
   endtask

   task automatic idle(input int n, input logic [7:0] a);
      for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 8'h0, 16'h0, a);
   endtask

   initial begin
      logic [3:0] op;
      reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_data = 8'h0;
      cmd_loc = 16'h0; alb = 8'h0;
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b0;
      idle(1, 8'h0);

      // In-order issue of three back-to-back commands
      drive(1'b1, 4'h4, 8'h00, 16'h0000, 8'h0);
      drive(1'b1, 4'h8, 8'h05, 16'h0000, 8'h0);
      drive(1'b1, 4'h5, 8'h00, 16'h0000, 8'h0);
      idle(4, 8'h0);

      // Fill FIFO while halted, fifth held, then RESET while full
      drive(1'b1, 4'hD, 8'h00, 16'h0000, 8'h0);
      idle(2, 8'h0);
      for (int i = 0; i < 5; i++) drive(1'b1, 4'h7, 8'(i), 16'(16'h100 + i), 8'h0);
      drive(1'b1, 4'h9, 8'h55, 16'h0000, 8'h0);
      drive(1'b1, 4'hC, 8'h00, 16'h0000, 8'h0);
      idle(3, 8'h0);

      // GOTO with arrival after a few polls, next command follows
      drive(1'b1, 4'h6, 8'h00, 16'h1234, 8'h0);
      drive(1'b1, 4'h5, 8'h00, 16'h0000, 8'h0);
      idle(2, 8'h0);
      idle(1, 8'h01);
      idle(4, 8'h0);

      // GOTO timeout, sticky error, cleared by RESET
      drive(1'b1, 4'h6, 8'h00, 16'hBEEF, 8'h0);
      idle(14, 8'h0);
      drive(1'b1, 4'hC, 8'h00, 16'h0000, 8'h0);
      idle(2, 8'h0);

      // SHUTDOWN then TARGET; TARGET never issues
      drive(1'b1, 4'hD, 8'h00, 16'h0000, 8'h0);
      drive(1'b1, 4'h7, 8'h00, 16'hABCD, 8'h0);
      idle(6, 8'h0);
      drive(1'b1, 4'hC, 8'h00, 16'h0000, 8'h0);
      idle(3, 8'h0);

      // Discarded opcodes, then port reset in WAIT_LOC and together with RESET command
      drive(1'b1, 4'hE, 8'h12, 16'h3456, 8'h0);
      drive(1'b1, 4'h0, 8'h00, 16'h0000, 8'h0);
      idle(2, 8'h0);
      drive(1'b1, 4'h6, 8'h00, 16'h4321, 8'h0);
      drive(1'b1, 4'h8, 8'h77, 16'h0000, 8'h0);
      idle(2, 8'h0);
      reset = 1'b1;
      idle(1, 8'h0);
      reset = 1'b0;
      idle(2, 8'h0);
      drive(1'b1, 4'h4, 8'h00, 16'h0000, 8'h0);
      reset = 1'b1;
      drive(1'b1, 4'hC, 8'h00, 16'h0000, 8'h0);
      reset = 1'b0;
      idle(2, 8'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'hC && $urandom_range(0, 7) != 0) op = 4'h6;
         reset = ($urandom_range(0, 149) == 0);
         drive(1'($urandom_range(0, 1)), op, 8'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h0);
      end
      reset = 1'b0;
      drive(1'b1, 4'hC, 8'h00, 16'h0000, 8'h0);
      idle(4, 8'h0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
